vga_timing_gen: RTL and testbench

//  Source end of the pixel-stream interface consumed by the drawing stages (menu, road, cars).

---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_timing_gen_if.sv | 25 ++
 rtl/vga_axis_counter.sv | 59 +++++
 rtl/vga_timing_gen.sv | 59 +++++
 tb/tb_vga_timing_gen.sv | 137 +++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared XGA (1024x768@60) timing constants and helpers for the video pipeline.
// Drawing stages import this for screen bounds as well.
package vga_timing_pkg;

  localparam int COUNT_W     = 11;
  localparam int FRAME_CNT_W = 16;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;
  localparam logic SYNC_POL         = SYNC_ACTIVE_LOW;

  localparam int SCREEN_MAX_X = H_ACTIVE - 1;
  localparam int SCREEN_MAX_Y = V_ACTIVE - 1;

  function automatic bit fits_count_w(input int total);
    return (total >= 1) && (total <= (2 ** COUNT_W) - 1);
  endfunction

  function automatic logic in_range(input logic [COUNT_W-1:0] x,
                                    input logic [COUNT_W-1:0] lo,
                                    input logic [COUNT_W-1:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-stream timing bundle: the generator drives it, drawing stages consume it.
// pix_en is driven by the consumer side and freezes the whole stream when low.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic                   pix_en;
  logic [COUNT_W-1:0]     hcount;
  logic [COUNT_W-1:0]     vcount;
  logic                   hsync;
  logic                   vsync;
  logic                   hblnk;
  logic                   vblnk;
  logic                   frame_start;
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport master (
    input  pix_en,
    output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
  );

  modport slave (
    output pix_en,
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus registered sync/blank flags.
// Flags are decoded from the next count so they line up with count_o.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = H_ACTIVE,
  parameter int   FP     = H_FP,
  parameter int   SYNC   = H_SYNC,
  parameter int   BP     = H_BP,
  parameter logic POL    = SYNC_POL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               carry_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               sync_o,
  output logic               blnk_o,
  output logic               wrap_o
);
  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [COUNT_W-1:0] LAST       = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] SYNC_FIRST = COUNT_W'(ACTIVE + FP);
  localparam logic [COUNT_W-1:0] SYNC_LAST  = COUNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [COUNT_W-1:0] BLNK_FIRST = COUNT_W'(ACTIVE);

  logic [COUNT_W-1:0] count_q, count_d;
  logic               sync_q, sync_d;
  logic               blnk_q, blnk_d;
  logic               step;

  assign step   = en_i & carry_i;
  assign wrap_o = step && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (step) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
    sync_d = in_range(count_d, SYNC_FIRST, SYNC_LAST) ? POL : ~POL;
    blnk_d = (count_d >= BLNK_FIRST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      sync_q  <= ~POL;
      blnk_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      blnk_q  <= blnk_d;
    end
  end

  assign count_o = count_q;
  assign sync_o  = sync_q;
  assign blnk_o  = blnk_q;
endmodule

// File: rtl/vga_timing_gen.sv
// Video pipeline source: H/V timing counters plus frame-start strobe and frame counter.
// Every output is a register describing the same (hcount,vcount) position.
module vga_timing_gen #(
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (!vga_timing_pkg::fits_count_w(H_TOTAL) || !vga_timing_pkg::fits_count_w(V_TOTAL)) begin : g_width_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit the 11-bit counters");
  end

  logic h_wrap, v_wrap;
  logic frame_start_q;
  logic [vga_timing_pkg::FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(SYNC_POL)
  ) u_h (
    .clk(clk), .rst(rst), .en_i(vga.pix_en), .carry_i(1'b1),
    .count_o(vga.hcount), .sync_o(vga.hsync), .blnk_o(vga.hblnk), .wrap_o(h_wrap)
  );

  // Lines advance only on a line wrap, so vsync can only move with hcount -> 0.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(SYNC_POL)
  ) u_v (
    .clk(clk), .rst(rst), .en_i(vga.pix_en), .carry_i(h_wrap),
    .count_o(vga.vcount), .sync_o(vga.vsync), .blnk_o(vga.vblnk), .wrap_o(v_wrap)
  );

  assign frame_cnt_d = v_wrap ? frame_cnt_q + 1'b1 : frame_cnt_q;

  // v_wrap already carries pix_en, so a frozen stream never strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= v_wrap;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vga.frame_start = frame_start_q;
  assign vga.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: an XGA instance and a shrunken-timing instance share stimulus;
// expected outputs come from position arithmetic on the count of enabled cycles.
module tb_vga_timing_gen;
  localparam int SM_HA = 16, SM_HF = 2, SM_HS = 3, SM_HB = 4;
  localparam int SM_VA = 8,  SM_VF = 1, SM_VS = 2, SM_VB = 3;
  localparam int SM_HT = SM_HA + SM_HF + SM_HS + SM_HB;
  localparam int SM_VT = SM_VA + SM_VF + SM_VS + SM_VB;
  localparam int SM_F  = SM_HT * SM_VT;
  localparam int XG_HT = 1344;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  longint n = 0;
  logic adv = 1'b0;

  logic [42:0] exp_xg_q[$];
  logic [42:0] exp_sm_q[$];

  always #5 clk = ~clk;

  vga_timing_gen_if xg_if ();
  vga_timing_gen_if sm_if ();
  assign xg_if.pix_en = pix_en;
  assign sm_if.pix_en = pix_en;

  vga_timing_gen dut_xga (.clk(clk), .rst(rst), .vga(xg_if));

  vga_timing_gen #(
    .H_ACTIVE(SM_HA), .H_FP(SM_HF), .H_SYNC(SM_HS), .H_BP(SM_HB),
    .V_ACTIVE(SM_VA), .V_FP(SM_VF), .V_SYNC(SM_VS), .V_BP(SM_VB),
    .SYNC_POL(1'b1)
  ) dut_small (.clk(clk), .rst(rst), .vga(sm_if));

  // Position after n enabled cycles since reset; strobe only if the last edge advanced onto (0,0).
  function automatic logic [42:0] model(input longint cnt, input logic advanced,
                                        input int ha, input int hf, input int hs, input int hb,
                                        input int va, input int vf, input int vs, input int vb,
                                        input logic pol);
    longint ht, vt, f, h, v, fc;
    logic [10:0] h11, v11;
    logic [15:0] fc16;
    logic hsy, vsy, hbl, vbl, fs;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    f  = ht * vt;
    h  = cnt % ht;
    v  = (cnt / ht) % vt;
    fc = (cnt / f) % 65536;
    hsy = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
    vsy = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
    hbl = (h >= ha);
    vbl = (v >= va);
    fs  = advanced && (cnt % f == 0);
    h11 = 11'(h);
    v11 = 11'(v);
    fc16 = 16'(fc);
    return {h11, v11, hsy, vsy, hbl, vbl, fs, fc16};
  endfunction

  function automatic string fmt(input logic [42:0] x);
    return $sformatf("h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b fc=%0d",
                     x[42:32], x[31:21], x[20], x[19], x[18], x[17], x[16], x[15:0]);
  endfunction

  task automatic step(input logic r, input logic e);
    @(negedge clk);
    rst = r;
    pix_en = e;
    @(posedge clk);
    if (r) begin
      n = 0;
      adv = 1'b0;
    end else begin
      adv = e;
      if (e) n = n + 1;
    end
    exp_xg_q.push_back(model(n, adv, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b0));
    exp_sm_q.push_back(model(n, adv, SM_HA, SM_HF, SM_HS, SM_HB, SM_VA, SM_VF, SM_VS, SM_VB, 1'b1));
  endtask

  always @(negedge clk) begin
    logic [42:0] exp_v, act_v;
    if (exp_xg_q.size() > 0) begin
      exp_v = exp_xg_q.pop_front();
      act_v = {xg_if.hcount, xg_if.vcount, xg_if.hsync, xg_if.vsync,
               xg_if.hblnk, xg_if.vblnk, xg_if.frame_start, xg_if.frame_cnt};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL xga t=%0t got %s want %s", $time, fmt(act_v), fmt(exp_v));
      end
    end
    if (exp_sm_q.size() > 0) begin
      exp_v = exp_sm_q.pop_front();
      act_v = {sm_if.hcount, sm_if.vcount, sm_if.hsync, sm_if.vsync,
               sm_if.hblnk, sm_if.vblnk, sm_if.frame_start, sm_if.frame_cnt};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL small t=%0t got %s want %s", $time, fmt(act_v), fmt(exp_v));
      end
    end
  end

  initial begin
    // Reset, then release and run up to the last pixel of the small frame.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < SM_F - 1; i++) step(1'b0, 1'b1);
    // Freeze on (last,last): no strobe, no movement; then wrap once.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    // Random enable pattern across a couple of small frames.
    for (int i = 0; i < 800; i++) step(1'b0, ($urandom_range(0, 9) < 8));
    // Reset while the small instance sits in its vsync lines.
    for (int i = 0; i < SM_F && ((n % SM_F) / SM_HT) != SM_VA + SM_VF; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < SM_F + 30; i++) step(1'b0, 1'b1);
    // Several continuous XGA lines: hblnk/hsync edges and line wraps.
    step(1'b1, 1'b0);
    for (int i = 0; i < 3 * XG_HT + 20; i++) step(1'b0, 1'b1);
    // Random enable with occasional resets.
    for (int i = 0; i < 2000; i++) step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_xg_q.size() != 0 || exp_sm_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", exp_xg_q.size(), exp_sm_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
